// File: rtl/systolic_mmu_ws_if.sv
// rtl/systolic_mmu_ws_if.sv - weight, input and result ports of systolic_mmu_ws
//
// Purpose: bundles the weight-load handshake, the input-vector handshake,
// the reload request and the result/status outputs of the matrix unit.
// Ports (slave = the matrix unit):
//   wt_valid/wt_ready/wt_row  one row of W per handshake, element j at [j*DATA_W +: DATA_W]
//   reload                    one-cycle request to replace W
//   in_valid/in_ready/in_vec  input vector x, element i at [i*DATA_W +: DATA_W]
//   out_valid/out_vec         result y = x*W, element j at [j*ACC_W +: ACC_W]
//   busy                      draining or vectors still in flight
interface systolic_mmu_ws_if #(
  parameter int SIZE   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic                    wt_valid;
  logic                    wt_ready;
  logic [SIZE*DATA_W-1:0]  wt_row;
  logic                    reload;
  logic                    in_valid;
  logic                    in_ready;
  logic [SIZE*DATA_W-1:0]  in_vec;
  logic                    out_valid;
  logic [SIZE*ACC_W-1:0]   out_vec;
  logic                    busy;

  modport master (
    output wt_valid, wt_row, reload, in_valid, in_vec,
    input  wt_ready, in_ready, out_valid, out_vec, busy
  );

  modport slave (
    input  wt_valid, wt_row, reload, in_valid, in_vec,
    output wt_ready, in_ready, out_valid, out_vec, busy
  );
endinterface

// File: rtl/systolic_mmu_ws.sv
// rtl/systolic_mmu_ws.sv - weight-stationary SIZE x SIZE systolic matrix-multiply unit
//
// Purpose: holds a signed weight matrix W, streams input vectors x through a
// skewed PE grid and emits y = x*W one vector per cycle, 2*SIZE cycles after
// acceptance. Owns the LOAD -> RUN -> DRAIN -> LOAD sequencing.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  systolic_mmu_ws_if slave: weight load, input vectors, results, busy
module systolic_mmu_ws #(
  parameter int SIZE   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  systolic_mmu_ws_if.slave  bus
);
  localparam int K_W = $clog2(SIZE);
  localparam int LAT = 2 * SIZE;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]     state;
  logic [K_W-1:0] k;

  // PE(i,j) keeps W[i][j]; x flows right along row i, partial sums flow down column j.
  logic signed [DATA_W-1:0] w   [SIZE][SIZE];
  logic signed [DATA_W-1:0] skw [SIZE][SIZE];  // row i uses the first i stages
  logic signed [DATA_W-1:0] xr  [SIZE][SIZE];
  logic signed [ACC_W-1:0]  ps  [SIZE][SIZE];
  logic signed [ACC_W-1:0]  dsk [SIZE][SIZE];  // column j uses the first SIZE-j stages

  logic [LAT-1:0]        vpipe;
  logic                  out_valid_q;
  logic [SIZE*ACC_W-1:0] out_vec_q;

  logic wt_fire;
  logic in_fire;

  logic signed [DATA_W-1:0] x_acc [SIZE];
  logic signed [DATA_W-1:0] x_in  [SIZE][SIZE];
  logic signed [ACC_W-1:0]  p_in  [SIZE][SIZE];
  logic signed [ACC_W-1:0]  mac   [SIZE][SIZE];
  logic [SIZE*ACC_W-1:0]    y_aligned;

  assign wt_fire = bus.wt_valid & (state == ST_LOAD);
  assign in_fire = bus.in_valid & (state == ST_RUN);

  assign bus.wt_ready  = (state == ST_LOAD);
  assign bus.in_ready  = (state == ST_RUN);
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;
  assign bus.busy      = (state == ST_DRAIN) | (|vpipe);

  always_comb begin
    x_acc     = '{default: '0};
    x_in      = '{default: '0};
    p_in      = '{default: '0};
    mac       = '{default: '0};
    y_aligned = '0;
    // Bubbles enter as zeros so idle PEs do not toggle on stale input data.
    for (int i = 0; i < SIZE; i++) begin
      x_acc[i] = in_fire ? bus.in_vec[i*DATA_W +: DATA_W] : '0;
    end
    // Row 0 takes x directly; row i takes x[i] after i skew stages.
    x_in[0][0] = x_acc[0];
    for (int i = 1; i < SIZE; i++) begin
      x_in[i][0] = skw[i][i-1];
    end
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 1; j < SIZE; j++) begin
        x_in[i][j] = xr[i][j-1];
      end
    end
    for (int i = 1; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        p_in[i][j] = ps[i-1][j];
      end
    end
    // Operands are sign-extended to ACC_W first, so the product wraps mod 2^ACC_W.
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        mac[i][j] = p_in[i][j] + ACC_W'(x_in[i][j]) * ACC_W'(w[i][j]);
      end
    end
    // Column j leaves the grid j cycles after column 0; tapping SIZE-j stages realigns them.
    for (int j = 0; j < SIZE; j++) begin
      y_aligned[j*ACC_W +: ACC_W] = dsk[j][SIZE-1-j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_LOAD;
      k           <= '0;
      vpipe       <= '0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          w[i][j]   <= '0;
          skw[i][j] <= '0;
          xr[i][j]  <= '0;
          ps[i][j]  <= '0;
          dsk[i][j] <= '0;
        end
      end
    end else begin
      case (state)
        ST_LOAD: begin
          if (wt_fire) begin
            if (k == K_W'(SIZE - 1)) begin
              k     <= '0;
              state <= ST_RUN;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.reload) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Leave once the final result is on the output (or nothing was in flight).
          if (vpipe == '0) state <= ST_LOAD;
        end
        default: state <= ST_LOAD;
      endcase

      for (int r = 0; r < SIZE; r++) begin
        for (int j = 0; j < SIZE; j++) begin
          if (wt_fire && (k == K_W'(r))) w[r][j] <= bus.wt_row[j*DATA_W +: DATA_W];
        end
      end

      for (int i = 0; i < SIZE; i++) begin
        skw[i][0] <= x_acc[i];
        for (int d = 1; d < SIZE; d++) begin
          skw[i][d] <= skw[i][d-1];
        end
        for (int j = 0; j < SIZE; j++) begin
          xr[i][j] <= x_in[i][j];
          ps[i][j] <= mac[i][j];
        end
      end

      for (int j = 0; j < SIZE; j++) begin
        dsk[j][0] <= ps[SIZE-1][j];
        for (int d = 1; d < SIZE; d++) begin
          dsk[j][d] <= dsk[j][d-1];
        end
      end

      vpipe       <= {vpipe[LAT-2:0], in_fire};
      out_valid_q <= vpipe[LAT-1];
      if (vpipe[LAT-1]) out_vec_q <= y_aligned;
    end
  end
endmodule

// File: tb/tb_systolic_mmu_ws.sv
// tb/tb_systolic_mmu_ws.sv - self-checking bench for systolic_mmu_ws
module tb_systolic_mmu_ws;
  localparam int SIZE   = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int LAT    = 2 * SIZE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  int wm [SIZE][SIZE];

  typedef struct {
    int                    cyc;
    logic [SIZE*ACC_W-1:0] vec;
  } ev_t;

  ev_t obs_q [$];
  ev_t exp_q [$];
  ev_t mon_e;

  systolic_mmu_ws_if #(.SIZE(SIZE), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();
  systolic_mmu_ws_if #(.SIZE(SIZE), .DATA_W(DATA_W), .ACC_W(16))    bus16 ();

  systolic_mmu_ws #(.SIZE(SIZE), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  systolic_mmu_ws #(.SIZE(SIZE), .DATA_W(DATA_W), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      mon_e.cyc = cyc;
      mon_e.vec = bus.out_vec;
      obs_q.push_back(mon_e);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 30000 cycles");
    $fatal(1);
  end

  // y[j] = sum_i x[i]*W[i][j], truncated to ACC_W bits.
  function automatic logic [SIZE*ACC_W-1:0] model_y(input logic [SIZE*DATA_W-1:0] xv);
    logic [SIZE*ACC_W-1:0] y;
    logic signed [DATA_W-1:0] xi;
    int s;
    y = '0;
    for (int j = 0; j < SIZE; j++) begin
      s = 0;
      for (int i = 0; i < SIZE; i++) begin
        xi = xv[i*DATA_W +: DATA_W];
        s += int'(xi) * wm[i][j];
      end
      y[j*ACC_W +: ACC_W] = s;
    end
    return y;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.wt_valid = 1'b0; bus.wt_row = '0; bus.reload = 1'b0; bus.in_valid = 1'b0; bus.in_vec = '0;
    bus16.wt_valid = 1'b0; bus16.wt_row = '0; bus16.reload = 1'b0; bus16.in_valid = 1'b0; bus16.in_vec = '0;
  endtask

  task automatic rand_w;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        wm[i][j] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic drive_row(input int r);
    logic [SIZE*DATA_W-1:0] row;
    for (int j = 0; j < SIZE; j++) row[j*DATA_W +: DATA_W] = DATA_W'(wm[r][j]);
    bus.wt_row   = row;
    bus.wt_valid = 1'b1;
    tick();
    bus.wt_valid = 1'b0;
  endtask

  task automatic load_weights;
    for (int r = 0; r < SIZE; r++) begin
      if ($urandom_range(0, 1) == 1) tick();
      drive_row(r);
    end
  endtask

  task automatic send(input logic [SIZE*DATA_W-1:0] xv);
    ev_t e;
    bus.in_valid = 1'b1;
    bus.in_vec   = xv;
    tick();
    bus.in_valid = 1'b0;
    e.cyc = cyc + LAT;
    e.vec = model_y(xv);
    exp_q.push_back(e);
  endtask

  task automatic bubble;
    bus.in_valid = 1'b0;
    bus.in_vec   = $urandom;
    tick();
  endtask

  task automatic reload_and_wait(output bit ok);
    int w;
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    w = 0;
    while (bus.wt_ready !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    ok = (bus.wt_ready === 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.wt_valid = 1'b1; bus.in_valid = 1'b1; bus.reload = 1'b1;
    bus.wt_row = $urandom; bus.in_vec = $urandom;
    repeat (3) tick();
    n_checks++; if (bus.wt_ready !== 1'b1) $display("FAIL reset_wt_ready: got %b expected 1", bus.wt_ready); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_vec !== '0) $display("FAIL reset_out_vec: got %h expected 0", bus.out_vec); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus16.out_vec !== '0) $display("FAIL reset_out_vec16: got %h expected 0", bus16.out_vec); else n_pass++;
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) wm[i][j] = 0;
  endtask

  task automatic test_identity;
    logic [SIZE*ACC_W-1:0] exp_id;
    int early;
    exp_id = {32'd4, 32'd3, 32'd2, 32'd1};
    for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) wm[i][j] = (i == j) ? 1 : 0;
    load_weights();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL load_to_run_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.wt_ready !== 1'b0) $display("FAIL run_wt_ready: got %b expected 0", bus.wt_ready); else n_pass++;
    bus.in_valid = 1'b1;
    bus.in_vec   = {8'd4, 8'd3, 8'd2, 8'd1};
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL identity_busy: got %b expected 1", bus.busy); else n_pass++;
    early = 0;
    repeat (LAT - 1) begin
      tick();
      if (bus.out_valid === 1'b1) early++;
    end
    n_checks++; if (early != 0) $display("FAIL identity_early: got %0d early pulses expected 0", early); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL identity_latency: got out_valid %b expected 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_vec !== exp_id) $display("FAIL identity_value: got %h expected %h", bus.out_vec, exp_id); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL identity_pulse_width: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_vec !== exp_id) $display("FAIL identity_hold: got %h expected %h", bus.out_vec, exp_id); else n_pass++;
    repeat (2) tick();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_signed;
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b0 || bus.wt_ready !== 1'b0) $display("FAIL empty_drain_state: got in_ready %b wt_ready %b expected 0 0", bus.in_ready, bus.wt_ready); else n_pass++;
    tick();
    n_checks++; if (bus.wt_ready !== 1'b1) $display("FAIL empty_drain_one_cycle: got wt_ready %b expected 1", bus.wt_ready); else n_pass++;
    for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) wm[i][j] = -128;
    load_weights();
    obs_q.delete(); exp_q.delete();
    send(32'h80808080);
    send(32'h0000007F);
    repeat (LAT + 3) tick();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL signed_count: got %0d results expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int n = 0; n < exp_q.size(); n++) begin
      n_checks++;
      if (n >= obs_q.size()) $display("FAIL signed_result[%0d]: got none expected %h", n, exp_q[n].vec);
      else if (obs_q[n].cyc != exp_q[n].cyc || obs_q[n].vec !== exp_q[n].vec)
        $display("FAIL signed_result[%0d]: got %h at %0d expected %h at %0d", n, obs_q[n].vec, obs_q[n].cyc, exp_q[n].vec, exp_q[n].cyc);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bubbles;
    logic [9:0] pat;
    bit ok;
    pat = 10'b1101101111;
    reload_and_wait(ok);
    n_checks++; if (!ok) $display("FAIL bubbles_reload_timeout: got wt_ready %b expected 1", bus.wt_ready); else n_pass++;
    rand_w();
    load_weights();
    obs_q.delete(); exp_q.delete();
    for (int c = 9; c >= 0; c--) begin
      if (pat[c]) send($urandom);
      else bubble();
    end
    repeat (LAT + 3) tick();
    n_checks++; if (obs_q.size() != 8) $display("FAIL bubbles_count: got %0d results expected 8", obs_q.size()); else n_pass++;
    for (int n = 0; n < exp_q.size(); n++) begin
      n_checks++;
      if (n >= obs_q.size()) $display("FAIL bubbles_result[%0d]: got none expected %h", n, exp_q[n].vec);
      else if (obs_q[n].cyc != exp_q[n].cyc || obs_q[n].vec !== exp_q[n].vec)
        $display("FAIL bubbles_result[%0d]: got %h at %0d expected %h at %0d", n, obs_q[n].vec, obs_q[n].cyc, exp_q[n].vec, exp_q[n].cyc);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    obs_q.delete(); exp_q.delete();
    for (int c = 0; c < 40; c++) begin
      if ($urandom_range(0, 3) != 0) send($urandom);
      else bubble();
    end
    repeat (LAT + 3) tick();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d results expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int n = 0; n < exp_q.size(); n++) begin
      n_checks++;
      if (n >= obs_q.size()) $display("FAIL b2b_result[%0d]: got none expected %h", n, exp_q[n].vec);
      else if (obs_q[n].cyc != exp_q[n].cyc || obs_q[n].vec !== exp_q[n].vec)
        $display("FAIL b2b_result[%0d]: got %h at %0d expected %h at %0d", n, obs_q[n].vec, obs_q[n].cyc, exp_q[n].vec, exp_q[n].cyc);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reload_midstream;
    int last_due;
    int w;
    int bad;
    obs_q.delete(); exp_q.delete();
    repeat (3) send($urandom);
    last_due = exp_q[$].cyc;
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL drain_in_ready: got %b expected 0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL drain_busy: got %b expected 1", bus.busy); else n_pass++;
    // Weight rows offered during DRAIN must not be taken.
    w = 0; bad = 0;
    while (bus.wt_ready !== 1'b1 && w < 40) begin
      if (bus.in_ready !== 1'b0) bad++;
      bus.wt_valid = 1'b1;
      bus.wt_row   = $urandom;
      tick();
      w++;
    end
    bus.wt_valid = 1'b0;
    n_checks++; if (bus.wt_ready !== 1'b1) $display("FAIL drain_timeout: got wt_ready %b expected 1", bus.wt_ready); else n_pass++;
    n_checks++; if (cyc != last_due + 1) $display("FAIL drain_exit_cycle: got %0d expected %0d", cyc, last_due + 1); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL drain_in_ready_low: got %0d cycles with in_ready expected 0", bad); else n_pass++;
    n_checks++; if (obs_q.size() != 3) $display("FAIL drain_count: got %0d results expected 3", obs_q.size()); else n_pass++;
    for (int n = 0; n < exp_q.size(); n++) begin
      n_checks++;
      if (n >= obs_q.size()) $display("FAIL drain_result[%0d]: got none expected %h", n, exp_q[n].vec);
      else if (obs_q[n].cyc != exp_q[n].cyc || obs_q[n].vec !== exp_q[n].vec)
        $display("FAIL drain_result[%0d]: got %h at %0d expected %h at %0d", n, obs_q[n].vec, obs_q[n].cyc, exp_q[n].vec, exp_q[n].cyc);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
    rand_w();
    load_weights();
    repeat (4) send($urandom);
    repeat (LAT + 3) tick();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL newW_count: got %0d results expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int n = 0; n < exp_q.size(); n++) begin
      n_checks++;
      if (n >= obs_q.size()) $display("FAIL newW_result[%0d]: got none expected %h", n, exp_q[n].vec);
      else if (obs_q[n].cyc != exp_q[n].cyc || obs_q[n].vec !== exp_q[n].vec)
        $display("FAIL newW_result[%0d]: got %h at %0d expected %h at %0d", n, obs_q[n].vec, obs_q[n].cyc, exp_q[n].vec, exp_q[n].cyc);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midstream;
    repeat (5) send($urandom);
    rst = 1'b1;
    bus.wt_valid = 1'b1; bus.in_valid = 1'b1; bus.wt_row = $urandom; bus.in_vec = $urandom;
    tick();
    rst = 1'b0;
    idle_inputs();
    obs_q.delete(); exp_q.delete();
    n_checks++; if (bus.wt_ready !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL rstmid_ready: got wt %b in %b expected 1 0", bus.wt_ready, bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_vec !== '0) $display("FAIL rstmid_out_vec: got %h expected 0", bus.out_vec); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", bus.busy); else n_pass++;
    repeat (LAT + 4) tick();
    n_checks++; if (obs_q.size() != 0) $display("FAIL rstmid_no_output: got %0d results expected 0", obs_q.size()); else n_pass++;
    // Reset during LOAD: the row counter must restart from 0.
    rand_w();
    drive_row(0);
    drive_row(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_row(0);
    drive_row(1);
    drive_row(2);
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL rstload_k: got in_ready %b expected 0 after 3 rows", bus.in_ready); else n_pass++;
    drive_row(3);
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstload_run: got in_ready %b expected 1 after 4 rows", bus.in_ready); else n_pass++;
    obs_q.delete(); exp_q.delete();
    repeat (2) send($urandom);
    repeat (LAT + 3) tick();
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rstload_count: got %0d results expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int n = 0; n < exp_q.size(); n++) begin
      n_checks++;
      if (n >= obs_q.size()) $display("FAIL rstload_result[%0d]: got none expected %h", n, exp_q[n].vec);
      else if (obs_q[n].cyc != exp_q[n].cyc || obs_q[n].vec !== exp_q[n].vec)
        $display("FAIL rstload_result[%0d]: got %h at %0d expected %h at %0d", n, obs_q[n].vec, obs_q[n].cyc, exp_q[n].vec, exp_q[n].cyc);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow;
    logic [SIZE*16-1:0]     exp16;
    logic [SIZE*DATA_W-1:0] xv;
    logic signed [DATA_W-1:0] xi;
    int s;
    int early;
    bus16.wt_valid = 1'b1;
    bus16.wt_row   = 32'h7F7F7F7F;
    repeat (SIZE) tick();
    // Keep offering a different row during RUN; it must be ignored.
    bus16.wt_row = 32'h01010101;
    n_checks++; if (bus16.in_ready !== 1'b1) $display("FAIL ovf_in_ready: got %b expected 1", bus16.in_ready); else n_pass++;
    for (int t = 0; t < 2; t++) begin
      xv = (t == 0) ? 32'h7F7F7F7F : $urandom;
      s = 0;
      for (int i = 0; i < SIZE; i++) begin
        xi = xv[i*DATA_W +: DATA_W];
        s += int'(xi) * 127;
      end
      for (int j = 0; j < SIZE; j++) exp16[j*16 +: 16] = s[15:0];
      bus16.in_valid = 1'b1;
      bus16.in_vec   = xv;
      tick();
      bus16.in_valid = 1'b0;
      early = 0;
      repeat (LAT - 1) begin
        tick();
        if (bus16.out_valid === 1'b1) early++;
      end
      tick();
      n_checks++; if (early != 0 || bus16.out_valid !== 1'b1) $display("FAIL ovf_latency[%0d]: got early %0d out_valid %b expected 0 1", t, early, bus16.out_valid); else n_pass++;
      n_checks++; if (bus16.out_vec !== exp16) $display("FAIL ovf_value[%0d]: got %h expected %h", t, bus16.out_vec, exp16); else n_pass++;
    end
    bus16.wt_valid = 1'b0;
    n_checks++; if (bus16.wt_ready !== 1'b0) $display("FAIL ovf_wt_ready: got %b expected 0", bus16.wt_ready); else n_pass++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_identity();
    test_signed();
    test_bubbles();
    test_back_to_back();
    test_reload_midstream();
    test_reset_midstream();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
